// File: rtl/ir_decoder.sv
// Pulse-distance IR frame receiver: a 4-unit start mark, then one 1-unit space plus a
// 1-unit (0) or 2-unit (1) mark per bit; a long space closes the frame.
module ir_decoder #(
  parameter int BASE_PULSE_WIDTH = 30000,
  parameter int TOL_PCT          = 1,
  parameter int MAX_BITS         = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ir,
  output logic [MAX_BITS-1:0] frame_data,
  output logic [4:0]          frame_len,
  output logic                frame_valid,
  input  logic                frame_ready,
  output logic                frame_repeat,
  output logic                overrun,
  output logic                err
);

  localparam int MIN1_I = 1 * BASE_PULSE_WIDTH * (100 - TOL_PCT) / 100;
  localparam int MAX1_I = 1 * BASE_PULSE_WIDTH * (100 + TOL_PCT) / 100;
  localparam int MIN2_I = 2 * BASE_PULSE_WIDTH * (100 - TOL_PCT) / 100;
  localparam int MAX2_I = 2 * BASE_PULSE_WIDTH * (100 + TOL_PCT) / 100;
  localparam int MIN4_I = 4 * BASE_PULSE_WIDTH * (100 - TOL_PCT) / 100;
  localparam int MAX4_I = 4 * BASE_PULSE_WIDTH * (100 + TOL_PCT) / 100;
  // Counter saturates at MAX(4)+1; one extra code keeps cnt+1 from wrapping.
  localparam int CW     = $clog2(MAX4_I + 3);

  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t MIN1 = cnt_t'(MIN1_I);
  localparam cnt_t MAX1 = cnt_t'(MAX1_I);
  localparam cnt_t MIN2 = cnt_t'(MIN2_I);
  localparam cnt_t MAX2 = cnt_t'(MAX2_I);
  localparam cnt_t MIN4 = cnt_t'(MIN4_I);
  localparam cnt_t MAX4 = cnt_t'(MAX4_I);
  localparam cnt_t SAT  = cnt_t'(MAX4_I + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_BIT   = 2'd3;

  logic                ir_s1, ir_s2, ir_d;
  logic                rise, fall;
  cnt_t                cnt, dur;
  logic                is1, is2, is4;
  logic [1:0]          state, state_nxt;
  logic [MAX_BITS-1:0] sh;
  logic [4:0]          bit_cnt;
  logic                clr, shift_en, complete, err_set, len_ok;
  logic [MAX_BITS-1:0] hist_data;
  logic [4:0]          hist_len;
  logic                have_hist, handshake, new_repeat;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_s1 <= 1'b1;
      ir_s2 <= 1'b1;
      ir_d  <= 1'b1;
    end else begin
      ir_s1 <= ir;
      ir_s2 <= ir_s1;
      ir_d  <= ir_s2;
    end
  end

  assign rise = ir_s2 & ~ir_d;
  assign fall = ~ir_s2 & ir_d;

  // cnt counts cycles since the current level began, so dur is the length of that level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               cnt <= '0;
    else if (rise || fall)    cnt <= '0;
    else if (cnt != SAT)      cnt <= cnt + cnt_t'(1);
  end

  assign dur = cnt + cnt_t'(1);
  assign is1 = (dur >= MIN1) && (dur <= MAX1);
  assign is2 = (dur >= MIN2) && (dur <= MAX2);
  assign is4 = (dur >= MIN4) && (dur <= MAX4);

  assign len_ok = ((bit_cnt == 5'd12) || (bit_cnt == 5'd15) || (bit_cnt == 5'd20))
                  && (bit_cnt <= 5'(MAX_BITS));

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    shift_en  = 1'b0;
    complete  = 1'b0;
    err_set   = 1'b0;
    case (state)
      S_IDLE: if (fall) state_nxt = S_START;
      S_START: begin
        if (rise) begin
          state_nxt = is4 ? S_PAUSE : S_IDLE;
          clr       = is4;
        end else if (!ir_s2 && dur > MAX4) begin
          state_nxt = S_IDLE;
        end
      end
      S_PAUSE: begin
        if (fall) begin
          state_nxt = is1 ? S_BIT : S_IDLE;
          err_set   = !is1;
        end else if (ir_s2 && dur > MAX2) begin
          state_nxt = S_IDLE;
          complete  = len_ok;
          err_set   = !len_ok;
        end
      end
      S_BIT: begin
        if (rise) begin
          if ((is1 || is2) && bit_cnt != 5'(MAX_BITS)) begin
            state_nxt = S_PAUSE;
            shift_en  = 1'b1;
          end else begin
            state_nxt = S_IDLE;
            err_set   = 1'b1;
          end
        end else if (!ir_s2 && dur > MAX2) begin
          state_nxt = S_IDLE;
          err_set   = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      sh      <= '0;
      bit_cnt <= '0;
      err     <= 1'b0;
    end else begin
      state <= state_nxt;
      err   <= err_set;
      if (clr) begin
        sh      <= '0;
        bit_cnt <= '0;
      end else if (shift_en) begin
        sh      <= {sh[MAX_BITS-2:0], is2};
        bit_cnt <= bit_cnt + 5'd1;
      end
    end
  end

  assign handshake  = frame_valid && frame_ready;
  assign new_repeat = have_hist && (hist_data == sh) && (hist_len == bit_cnt);

  // History tracks every completed frame, even one dropped on overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_data   <= '0;
      frame_len    <= '0;
      frame_valid  <= 1'b0;
      frame_repeat <= 1'b0;
      overrun      <= 1'b0;
      hist_data    <= '0;
      hist_len     <= '0;
      have_hist    <= 1'b0;
    end else begin
      if (complete) begin
        hist_data <= sh;
        hist_len  <= bit_cnt;
        have_hist <= 1'b1;
      end
      if (complete && frame_valid && !frame_ready) begin
        overrun <= 1'b1;
      end else begin
        if (handshake) overrun <= 1'b0;
        if (complete) begin
          frame_data   <= sh;
          frame_len    <= bit_cnt;
          frame_repeat <= new_repeat;
          frame_valid  <= 1'b1;
        end else if (handshake) begin
          frame_valid  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ir_decoder.sv
// Bench for ir_decoder: waveform generator plus a frame-level scoreboard that
// predicts each delivered frame and the number of malformed-frame errors.
module tb_ir_decoder;

  localparam int BASE = 100;
  localparam int MB   = 20;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ir;
  logic [MB-1:0] frame_data;
  logic [4:0]    frame_len;
  logic          frame_valid;
  logic          frame_ready;
  logic          frame_repeat;
  logic          overrun;
  logic          err;

  ir_decoder #(.BASE_PULSE_WIDTH(BASE), .TOL_PCT(1), .MAX_BITS(MB)) dut (
    .clk(clk), .rst_n(rst_n), .ir(ir),
    .frame_data(frame_data), .frame_len(frame_len), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .frame_repeat(frame_repeat),
    .overrun(overrun), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [MB-1:0] data;
    logic [4:0]    len;
    logic          rep;
  } frame_t;

  frame_t        exp_q[$];
  frame_t        mon_f;
  int            errors = 0;
  int            checks = 0;
  int            err_seen = 0;
  int            err_exp = 0;
  bit            jitter = 1'b0;
  bit            have_last = 1'b0;
  logic [MB-1:0] last_d;
  int            last_len;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Model of a frame the decoder completes: repeat is "same as the last completed one".
  function automatic logic model_complete(input logic [MB-1:0] d, input int len);
    logic r;
    r = have_last && (last_d == d) && (last_len == len);
    have_last = 1'b1;
    last_d    = d;
    last_len  = len;
    return r;
  endfunction

  task automatic expect_frame(input logic [MB-1:0] d, input int len);
    frame_t f;
    f.data = d;
    f.len  = 5'(len);
    f.rep  = model_complete(d, len);
    exp_q.push_back(f);
  endtask

  function automatic int units(input int k);
    if (!jitter) return k * BASE;
    return k * BASE + int'($urandom_range(2 * k, 0)) - k;
  endfunction

  task automatic hold(input logic v, input int n);
    ir = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // bad_bit >= 0 stretches that bit's mark to 150 cycles; start_len 0 means a normal start.
  task automatic send_frame(input logic [MB-1:0] d, input int len, input int bad_bit,
                            input int start_len);
    hold(1'b0, (start_len == 0) ? units(4) : start_len);
    for (int i = len - 1; i >= 0; i--) begin
      hold(1'b1, units(1));
      if (i == bad_bit) hold(1'b0, 150);
      else              hold(1'b0, d[i] ? units(2) : units(1));
    end
    hold(1'b1, 300);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (err) err_seen++;
      if (frame_valid && frame_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 32'(frame_data), 32'hFFFF_FFFF);
        end else begin
          mon_f = exp_q.pop_front();
          check("frame_data",   32'(frame_data),   32'(mon_f.data));
          check("frame_len",    32'(frame_len),    32'(mon_f.len));
          check("frame_repeat", 32'(frame_repeat), 32'(mon_f.rep));
        end
      end
    end
  end

  task automatic phase_end(input string tag);
    check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_errs"},    32'(err_seen),     32'(err_exp));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"},   32'(frame_valid),  32'd0);
    check({tag, "_data"},    32'(frame_data),   32'd0);
    check({tag, "_len"},     32'(frame_len),    32'd0);
    check({tag, "_repeat"},  32'(frame_repeat), 32'd0);
    check({tag, "_overrun"}, 32'(overrun),      32'd0);
    check({tag, "_err"},     32'(err),          32'd0);
  endtask

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [MB-1:0] rd;
    int            rl;
    rst_n       = 1'b0;
    ir          = 1'b1;
    frame_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    hold(1'b1, 50);

    // Basic decode, repeat detection, 15- and 20-bit lengths.
    expect_frame(20'h00A5C, 12); send_frame(20'h00A5C, 12, -1, 0);
    expect_frame(20'h00A5C, 12); send_frame(20'h00A5C, 12, -1, 0);
    expect_frame(20'h01234, 15); send_frame(20'h01234, 15, -1, 0);
    expect_frame(20'hF00F1, 20); send_frame(20'hF00F1, 20, -1, 0);
    phase_end("basic");

    // Overrun: second frame dropped while first is held.
    frame_ready = 1'b0;
    expect_frame(20'h00111, 12); send_frame(20'h00111, 12, -1, 0);
    void'(model_complete(20'h00222, 12)); send_frame(20'h00222, 12, -1, 0);
    check("held_valid",   32'(frame_valid), 32'd1);
    check("held_data",    32'(frame_data),  32'h111);
    check("overrun_set",  32'(overrun),     32'd1);
    frame_ready = 1'b1;
    @(posedge clk); #1;
    frame_ready = 1'b0;
    check("post_hs_valid",   32'(frame_valid), 32'd0);
    check("post_hs_overrun", 32'(overrun),     32'd0);
    frame_ready = 1'b1;
    phase_end("overrun");

    // Malformed frames: long bit mark, illegal length; bad start widths are silent.
    send_frame(20'h00A5C, 12, 5, 0);   err_exp++;
    send_frame(20'h01ABC, 13, -1, 0);  err_exp++;
    send_frame(20'h00A5C, 12, -1, 390);
    send_frame(20'h00A5C, 12, -1, 410);
    phase_end("malformed");
    expect_frame(20'h00222, 12); send_frame(20'h00222, 12, -1, 0);
    phase_end("after_drop");

    // Reset mid-frame with a frame held: everything clears, history included.
    frame_ready = 1'b0;
    void'(model_complete(20'h00333, 12)); send_frame(20'h00333, 12, -1, 0);
    check("pre_reset_valid", 32'(frame_valid), 32'd1);
    hold(1'b0, 400);
    for (int i = 0; i < 5; i++) begin
      hold(1'b1, 100);
      hold(1'b0, (i % 2 == 0) ? 200 : 100);
    end
    ir = 1'b1;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    have_last = 1'b0;
    frame_ready = 1'b1;
    hold(1'b1, 10);
    rst_n = 1'b1;
    hold(1'b1, 50);
    expect_frame(20'h00333, 12); send_frame(20'h00333, 12, -1, 0);
    phase_end("reset");

    // Randomized frames with timing jitter inside the tolerance window.
    jitter = 1'b1;
    rd = 20'h00A5C;
    rl = 12;
    for (int n = 0; n < 4; n++) begin
      if ($urandom_range(2, 0) != 0) begin
        case ($urandom_range(2, 0))
          0:       rl = 12;
          1:       rl = 15;
          default: rl = 20;
        endcase
        rd = MB'($urandom) & MB'((1 << rl) - 1);
      end
      expect_frame(rd, rl);
      send_frame(rd, rl, -1, 0);
    end
    phase_end("random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ir_decoder.md
IR_DECODER -- requirements
Module: ir_decoder

Interface
REQ-001 SHALL have parameter BASE_PULSE_WIDTH, default 30000, meaning clk cycles per base unit (600 us).
REQ-002 SHALL have parameter TOL_PCT, default 1, meaning allowed timing deviation in percent (0..20).
REQ-003 SHALL have parameter MAX_BITS, default 20, meaning frame_data width and longest accepted frame (12..20).
REQ-004 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port ir  input  1  raw asynchronous demodulated IR level, 0 = mark.
REQ-007 SHALL have port frame_data  output  MAX_BITS  received bits, first bit at index frame_len-1, bits above zero.
REQ-008 SHALL have port frame_len  output  5  bit count of held frame (12, 15 or 20).
REQ-009 SHALL have port frame_valid  output  1  held frame available.
REQ-010 SHALL have port frame_ready  input  1  consumer accepts held frame.
REQ-011 SHALL have port frame_repeat  output  1  held frame equals the previously completed frame (data and length).
REQ-012 SHALL have port overrun  output  1  sticky flag, a completed frame was dropped.
REQ-013 SHALL have port err  output  1  one-cycle pulse on malformed frame.

Function
REQ-014 SHALL pass ir through a 2-flop synchroniser reset to 1; all decoding uses the synchronised level.
REQ-015 SHALL derive MIN(k) = k*BASE*(100-TOL_PCT)/100 and MAX(k) = k*BASE*(100+TOL_PCT)/100, integer, k in {1,2,4}; a duration d matches k if MIN(k) <= d <= MAX(k).
REQ-016 SHALL use one duration counter sized for MAX(4)+1, reset to 0 at each accepted level change, saturating (never wrapping).
REQ-017 SHALL implement states IDLE, START, PAUSE, BIT.
REQ-018 IDLE SHALL move to START only on a 1->0 edge of synchronised ir, never on a held-low level.
REQ-019 START: on rising edge, duration matching 4 -> PAUSE, clear shift register and bit count; otherwise -> IDLE silently; low exceeding MAX(4) -> IDLE silently.
REQ-020 PAUSE: on falling edge, duration matching 1 -> BIT; otherwise -> IDLE with err.
REQ-021 BIT: on rising edge, duration matching 1 shifts in 0, matching 2 shifts in 1, bit count +1, -> PAUSE; otherwise, or low exceeding MAX(2), -> IDLE with err.
REQ-022 A shift that would exceed MAX_BITS bits SHALL abort to IDLE with err.
REQ-023 PAUSE with high duration exceeding MAX(2) SHALL end the frame: bit count in {12,15,20} and <= MAX_BITS -> complete; otherwise err; -> IDLE either way.
REQ-024 On completion frame_data/frame_len/frame_repeat SHALL load and frame_valid assert on the next clk edge.
REQ-025 frame_data, frame_len, frame_repeat SHALL stay stable while frame_valid=1 and frame_ready=0.
REQ-026 frame_valid SHALL deassert the cycle after a cycle with frame_valid=1 and frame_ready=1.
REQ-027 Completion while frame_valid=1 and frame_ready=0 SHALL drop the new frame and set overrun; held frame unchanged.
REQ-028 Completion in the same cycle as a handshake SHALL load the new frame, keep frame_valid=1, and not set overrun.
REQ-029 overrun SHALL clear on the edge following a handshake cycle unless set in that same cycle.
REQ-030 frame_repeat compare SHALL use the last completed frame, including dropped ones; first frame after reset has frame_repeat=0.
REQ-031 err SHALL be high exactly one cycle per malformed frame.

Reset
REQ-032 rst_n=0 SHALL immediately force state IDLE, counter 0, frame_data 0, frame_len 0, frame_valid 0, frame_repeat 0, overrun 0, err 0, repeat history cleared, synchroniser 1.
REQ-033 Reset mid-frame SHALL discard the partial frame without err; decoding resumes with the next start pulse.

Verification (BASE_PULSE_WIDTH=100, TOL_PCT=1, MAX_BITS=20, frame_ready=1 unless stated)
REQ-034 12-bit frame 0xA5C (400 low, then per bit 100 high + 100/200 low, 300 high idle) -> one frame_valid, frame_data=0x00A5C, frame_len=12, frame_repeat=0, err never high.
REQ-035 Same frame sent twice, then 15-bit 0x1234 and 20-bit 0xF00F1 -> second 0xA5C has frame_repeat=1; next two decode with frame_len 15 and 20, frame_repeat=0.
REQ-036 frame_ready=0, frames 0x111 then 0x222 -> held 0x111, overrun=1; raise frame_ready one cycle -> frame_valid 0, overrun 0 next cycle.
REQ-037 Bit mark of 150 cycles, and separately a 13-bit frame -> one err pulse each, no frame_valid.
REQ-038 Start pulses of 390 and 410 low -> silent return to IDLE, no err; rst_n=0 after 5 bits of a frame -> all outputs 0, next full frame decodes correctly.
